multi_digit_7seg_counter: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 55 +++++
 rtl/seven_seg_decoder.sv | 18 +
 rtl/multi_digit_7seg_counter.sv | 173 +++++++++++++++++
 tb/tb_multi_digit_7seg_counter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// seven_seg_pkg : 7-segment decode constants, digit limits and decode helper
// Revision 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [3:0] MAX_BCD = 4'd9;
  localparam logic [3:0] MAX_HEX = 4'hF;

  // Segment order is {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// ============================================================================
// seven_seg_decoder : combinational nibble to {g..a} segment pattern
// Revision 1.0
// ============================================================================
`default_nettype none

module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = seg_decode(nibble);

endmodule

`default_nettype wire

// File: rtl/multi_digit_7seg_counter.sv
// ============================================================================
// multi_digit_7seg_counter : N-digit BCD/hex up/down counter with scanned
//                            7-segment driver
// Revision 1.0
// ============================================================================
`default_nettype none

module multi_digit_7seg_counter
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int BCD_MODE       = 1,
  parameter int SCAN_DIV       = 1024,
  parameter int ACTIVE_LOW_OUT = 0
) (
  input  logic                  input_clock,
  input  logic                  input_reset_n,
  input  logic                  count_btn,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count_value,
  output logic                  carry_out,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int         IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int         PRE_W     = $clog2(SCAN_DIV);
  localparam logic [3:0] DIGIT_MAX = (BCD_MODE != 0) ? MAX_BCD : MAX_HEX;

  logic                 btn_sync1, btn_sync2, btn_prev;
  logic [1:0]           warm;
  logic                 armed;
  logic                 step_pulse;

  logic [4*DIGITS-1:0]  count_q, count_d, load_clean;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 ripple;
  logic [3:0]           dig;

  logic [PRE_W-1:0]     prescale_q;
  logic                 scan_tick;
  logic [IDX_W-1:0]     scan_idx, next_idx;
  logic [3:0]           scan_nibble;
  logic [6:0]           scan_segments;
  logic [7:0]           seg_q;
  logic [DIGITS-1:0]    sel_q;

  // A button held through reset must be seen low once (after the synchroniser
  // has filled with real samples) before any rising edge counts as a step.
  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_prev  <= 1'b0;
      warm      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      btn_sync1 <= count_btn;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
      warm      <= {warm[0], 1'b1};
      armed     <= armed | (warm[1] & ~btn_sync2);
    end
  end

  assign step_pulse = btn_sync2 & ~btn_prev & armed;

  always_comb begin
    load_clean = load_value;
    for (int d = 0; d < DIGITS; d++) begin
      if ((BCD_MODE != 0) && (load_value[4*d +: 4] > MAX_BCD)) begin
        load_clean[4*d +: 4] = 4'h0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    ripple  = 1'b0;
    dig     = 4'h0;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clean;
    end else if (step_pulse) begin
      ripple = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
        if (ripple) begin
          dig = count_q[4*d +: 4];
          if (up_down) begin
            ripple              = (dig == DIGIT_MAX);
            count_d[4*d +: 4]   = ripple ? 4'h0 : dig + 4'h1;
          end else begin
            ripple              = (dig == 4'h0);
            count_d[4*d +: 4]   = ripple ? DIGIT_MAX : dig - 4'h1;
          end
        end
      end
      carry_d = ripple;
      ovf_d   = ovf_q | ripple;
    end
  end

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign scan_tick = (prescale_q == PRE_W'(SCAN_DIV - 1));
  assign next_idx  = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);

  always_comb begin
    scan_nibble = count_q[3:0];
    for (int d = 0; d < DIGITS; d++) begin
      if (next_idx == IDX_W'(d)) begin
        scan_nibble = count_q[4*d +: 4];
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble   (scan_nibble),
    .segments (scan_segments)
  );

  // Anode and segment registers load on the same edge so the pins never
  // show one digit's pattern on another digit's anode.
  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      prescale_q <= '0;
      scan_idx   <= '0;
      seg_q      <= 8'h00;
      sel_q      <= '0;
    end else if (scan_tick) begin
      prescale_q <= '0;
      scan_idx   <= next_idx;
      seg_q      <= {(next_idx == '0) & ovf_q, scan_segments};
      sel_q      <= DIGITS'(1) << next_idx;
    end else begin
      prescale_q <= prescale_q + PRE_W'(1);
    end
  end

  assign count_value = count_q;
  assign carry_out   = carry_q;

  generate
    if (ACTIVE_LOW_OUT != 0) begin : g_active_low
      assign seg_out   = ~seg_q;
      assign digit_sel = ~sel_q;
    end else begin : g_active_high
      assign seg_out   = seg_q;
      assign digit_sel = sel_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_digit_7seg_counter.sv
// ============================================================================
// tb_multi_digit_7seg_counter : BCD/active-high and hex/active-low instances
//                               driven together against an integer model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multi_digit_7seg_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        count_btn = 1'b0;
  logic        up_down = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;

  logic [15:0] count_bcd, count_hex;
  logic        carry_bcd, carry_hex;
  logic [7:0]  seg_bcd, seg_hex;
  logic [3:0]  sel_bcd, sel_hex;

  int errors = 0;
  int checks = 0;

  int m_bcd = 0;
  int m_hex = 0;
  bit ovf_bcd = 0, ovf_hex = 0, wrap_bcd = 0, wrap_hex = 0;

  logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  multi_digit_7seg_counter #(.DIGITS(4), .BCD_MODE(1), .SCAN_DIV(4), .ACTIVE_LOW_OUT(0)) dut_bcd (
    .input_clock(clk), .input_reset_n(rst_n), .count_btn(count_btn), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count_value(count_bcd),
    .carry_out(carry_bcd), .seg_out(seg_bcd), .digit_sel(sel_bcd));

  multi_digit_7seg_counter #(.DIGITS(4), .BCD_MODE(0), .SCAN_DIV(4), .ACTIVE_LOW_OUT(1)) dut_hex (
    .input_clock(clk), .input_reset_n(rst_n), .count_btn(count_btn), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count_value(count_hex),
    .carry_out(carry_hex), .seg_out(seg_hex), .digit_sel(sel_hex));

  // ---------------- reference model: counts held as plain integers ----------
  function automatic logic [15:0] bcd_pack(input int v);
    logic [15:0] r;
    int p;
    r = 16'h0;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int bcd_from_load(input logic [15:0] lv);
    int v, p, n;
    v = 0;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      n = int'(lv[4*d +: 4]);
      if (n > 9) n = 0;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic void model_step(input bit dir);
    if (dir) begin
      wrap_bcd = (m_bcd == 9999);  m_bcd = (m_bcd + 1) % 10000;
      wrap_hex = (m_hex == 65535); m_hex = (m_hex + 1) % 65536;
    end else begin
      wrap_bcd = (m_bcd == 0); m_bcd = (m_bcd + 9999) % 10000;
      wrap_hex = (m_hex == 0); m_hex = (m_hex + 65535) % 65536;
    end
    ovf_bcd = ovf_bcd | wrap_bcd;
    ovf_hex = ovf_hex | wrap_hex;
  endfunction

  function automatic void model_reset();
    m_bcd = 0; m_hex = 0; ovf_bcd = 0; ovf_hex = 0;
  endfunction

  // ---------------- stimulus tasks (drive + model update only) --------------
  task automatic do_press(input bit dir, output int cb, output int ch);
    @(negedge clk);
    up_down   = dir;
    count_btn = 1'b1;
    model_step(dir);
    cb = 0;
    ch = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (carry_bcd === 1'b1) cb++;
      if (carry_hex === 1'b1) ch++;
      if (i == 2) count_btn = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load_value = v;
    load = 1'b1;
    m_bcd = bcd_from_load(v);
    m_hex = int'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    model_reset();
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Waits for a fresh entry into the digit-0 scan slot.
  task automatic wait_slot0(output bit ok);
    bit left;
    left = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sel_bcd !== 4'b0001) left = 1;
      else if (left) ok = 1;
    end
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    #3;
    checks += 6;
    if (count_bcd !== 16'h0) begin errors++; $display("FAIL reset_count_bcd: got %h want 0000", count_bcd); end
    if (count_hex !== 16'h0) begin errors++; $display("FAIL reset_count_hex: got %h want 0000", count_hex); end
    if ({carry_bcd, carry_hex} !== 2'b00) begin errors++; $display("FAIL reset_carry: got %b want 00", {carry_bcd, carry_hex}); end
    if ({seg_bcd, sel_bcd} !== 12'h000) begin errors++; $display("FAIL reset_pins_high: got %h/%b want 00/0000", seg_bcd, sel_bcd); end
    if (seg_hex !== 8'hFF) begin errors++; $display("FAIL reset_seg_low: got %h want ff", seg_hex); end
    if (sel_hex !== 4'hF) begin errors++; $display("FAIL reset_sel_low: got %b want 1111", sel_hex); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_count_up();
    int cb, ch, tb, th;
    tb = 0; th = 0;
    for (int i = 0; i < 3; i++) begin
      do_press(1'b1, cb, ch);
      tb += cb; th += ch;
    end
    checks += 3;
    if (count_bcd !== 16'h0003) begin errors++; $display("FAIL up3_bcd: got %h want 0003", count_bcd); end
    if (count_hex !== 16'h0003) begin errors++; $display("FAIL up3_hex: got %h want 0003", count_hex); end
    if (tb + th != 0) begin errors++; $display("FAIL up3_carry: got %0d carry cycles want 0", tb + th); end
  endtask

  task automatic test_wrap_up();
    int cb, ch;
    bit ok;
    logic [15:0] hv;
    do_load(16'h9999);
    do_press(1'b1, cb, ch);
    hv = 16'(m_hex);
    checks += 4;
    if (count_bcd !== bcd_pack(m_bcd)) begin errors++; $display("FAIL wrapup_bcd: got %h want %h", count_bcd, bcd_pack(m_bcd)); end
    if (cb != int'(wrap_bcd)) begin errors++; $display("FAIL wrapup_carry_bcd: got %0d cycles want %0d", cb, wrap_bcd); end
    if (count_hex !== hv) begin errors++; $display("FAIL wrapup_hex: got %h want %h", count_hex, hv); end
    if (ch != int'(wrap_hex)) begin errors++; $display("FAIL wrapup_carry_hex: got %0d cycles want %0d", ch, wrap_hex); end
    wait_slot0(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL wrapup_slot0_timeout: got no digit-0 slot want one"); end
    if (seg_bcd !== {ovf_bcd, seg_tab[0]}) begin errors++; $display("FAIL wrapup_dp_bcd: got %h want %h", seg_bcd, {ovf_bcd, seg_tab[0]}); end
    if (seg_hex !== ~{ovf_hex, seg_tab[hv[3:0]]}) begin errors++; $display("FAIL wrapup_seg_hex: got %h want %h", seg_hex, ~{ovf_hex, seg_tab[hv[3:0]]}); end
    // dp must not appear on other digits.
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks += 1;
    if (sel_bcd === 4'b0010 && seg_bcd[7] !== 1'b0) begin errors++; $display("FAIL wrapup_dp_digit1: got %b want 0", seg_bcd[7]); end
    else if (sel_bcd !== 4'b0010) begin errors++; $display("FAIL wrapup_scan_order: got %b want 0010", sel_bcd); end
  endtask

  task automatic test_wrap_down();
    int cb, ch;
    do_clear();
    do_press(1'b0, cb, ch);
    checks += 4;
    if (count_bcd !== 16'h9999) begin errors++; $display("FAIL down_bcd: got %h want 9999", count_bcd); end
    if (cb != 1) begin errors++; $display("FAIL down_carry_bcd: got %0d cycles want 1", cb); end
    if (count_hex !== 16'hFFFF) begin errors++; $display("FAIL down_hex: got %h want ffff", count_hex); end
    if (ch != 1) begin errors++; $display("FAIL down_carry_hex: got %0d cycles want 1", ch); end
  endtask

  task automatic test_priority();
    bit ok;
    @(negedge clk); up_down = 1'b1; count_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1; load = 1'b1; load_value = 16'h1234;
    @(negedge clk);
    clear = 1'b0; load = 1'b0; count_btn = 1'b0;
    model_reset();
    checks += 3;
    if (count_bcd !== 16'h0) begin errors++; $display("FAIL prio_bcd: got %h want 0000", count_bcd); end
    if (count_hex !== 16'h0) begin errors++; $display("FAIL prio_hex: got %h want 0000", count_hex); end
    if ({carry_bcd, carry_hex} !== 2'b00) begin errors++; $display("FAIL prio_carry: got %b want 00", {carry_bcd, carry_hex}); end
    repeat (3) @(negedge clk);
    wait_slot0(ok);
    checks += 2;
    if (!ok || seg_bcd !== {1'b0, seg_tab[0]}) begin errors++; $display("FAIL prio_dp_bcd: got %h want %h", seg_bcd, {1'b0, seg_tab[0]}); end
    if (seg_hex !== ~{1'b0, seg_tab[0]}) begin errors++; $display("FAIL prio_dp_hex: got %h want %h", seg_hex, ~{1'b0, seg_tab[0]}); end
    do_load(16'h1A34);
    checks += 2;
    if (count_bcd !== 16'h1034) begin errors++; $display("FAIL load_bcd_sanitise: got %h want 1034", count_bcd); end
    if (count_hex !== 16'h1A34) begin errors++; $display("FAIL load_hex: got %h want 1a34", count_hex); end
  endtask

  task automatic test_random();
    int op, cb, ch;
    bit ok;
    logic [15:0] lv, hv, bv;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 5));
      cb = 0; ch = 0;
      wrap_bcd = 0; wrap_hex = 0;
      if (op == 3) begin
        case ($urandom_range(0, 3))
          0: lv = 16'h9999;
          1: lv = 16'hFFFF;
          2: lv = 16'h0000;
          default: lv = 16'($urandom_range(0, 65535));
        endcase
        do_load(lv);
      end else if (op == 4) begin
        do_clear();
      end else begin
        do_press(1'($urandom_range(0, 1)), cb, ch);
      end
      hv = 16'(m_hex);
      bv = bcd_pack(m_bcd);
      checks += 4;
      if (count_bcd !== bv) begin errors++; $display("FAIL rand_bcd[%0d]: got %h want %h", n, count_bcd, bv); end
      if (count_hex !== hv) begin errors++; $display("FAIL rand_hex[%0d]: got %h want %h", n, count_hex, hv); end
      if (cb != int'(wrap_bcd)) begin errors++; $display("FAIL rand_carry_bcd[%0d]: got %0d want %0d", n, cb, wrap_bcd); end
      if (ch != int'(wrap_hex)) begin errors++; $display("FAIL rand_carry_hex[%0d]: got %0d want %0d", n, ch, wrap_hex); end
    end
    wait_slot0(ok);
    hv = 16'(m_hex);
    bv = bcd_pack(m_bcd);
    checks += 2;
    if (!ok || seg_bcd !== {ovf_bcd, seg_tab[bv[3:0]]}) begin errors++; $display("FAIL rand_seg_bcd: got %h want %h", seg_bcd, {ovf_bcd, seg_tab[bv[3:0]]}); end
    if (seg_hex !== ~{ovf_hex, seg_tab[hv[3:0]]}) begin errors++; $display("FAIL rand_seg_hex: got %h want %h", seg_hex, ~{ovf_hex, seg_tab[hv[3:0]]}); end
  endtask

  task automatic test_scan();
    logic [15:0] v;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
    int idx;
    v = 16'h1234;
    @(negedge clk);
    rst_n = 1'b0;
    count_btn = 1'b0; clear = 1'b0; load = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    load = 1'b1;
    load_value = v;
    m_bcd = 1234;
    m_hex = 32'h1234;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) load = 1'b0;
      if (k == 3) begin
        checks++;
        if (sel_bcd !== 4'b0000) begin errors++; $display("FAIL scan_early: got %b want 0000", sel_bcd); end
      end
      if (k % 4 == 0) begin
        idx = (k / 4) % 4;
        exp_sel = 4'(1 << idx);
        exp_seg = {1'b0, seg_tab[v[4*idx +: 4]]};
        checks += 4;
        if (sel_bcd !== exp_sel) begin errors++; $display("FAIL scan_sel_bcd[%0d]: got %b want %b", k, sel_bcd, exp_sel); end
        if (seg_bcd !== exp_seg) begin errors++; $display("FAIL scan_seg_bcd[%0d]: got %h want %h", k, seg_bcd, exp_seg); end
        if (sel_hex !== ~exp_sel) begin errors++; $display("FAIL scan_sel_hex[%0d]: got %b want %b", k, sel_hex, ~exp_sel); end
        if (seg_hex !== ~exp_seg) begin errors++; $display("FAIL scan_seg_hex[%0d]: got %h want %h", k, seg_hex, ~exp_seg); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cb, ch;
    do_load(16'h0042);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks += 4;
    if ({count_bcd, count_hex} !== 32'h0) begin errors++; $display("FAIL midrst_count: got %h/%h want 0000/0000", count_bcd, count_hex); end
    if ({carry_bcd, carry_hex} !== 2'b00) begin errors++; $display("FAIL midrst_carry: got %b want 00", {carry_bcd, carry_hex}); end
    if ({seg_bcd, sel_bcd} !== 12'h000) begin errors++; $display("FAIL midrst_pins_high: got %h/%b want 00/0000", seg_bcd, sel_bcd); end
    if ({seg_hex, sel_hex} !== 12'hFFF) begin errors++; $display("FAIL midrst_pins_low: got %h/%b want ff/1111", seg_hex, sel_hex); end
    count_btn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks += 2;
    if (count_bcd !== 16'h0) begin errors++; $display("FAIL held_btn_bcd: got %h want 0000", count_bcd); end
    if (count_hex !== 16'h0) begin errors++; $display("FAIL held_btn_hex: got %h want 0000", count_hex); end
    count_btn = 1'b0;
    repeat (4) @(negedge clk);
    do_press(1'b1, cb, ch);
    checks += 2;
    if (count_bcd !== 16'h0001) begin errors++; $display("FAIL repress_bcd: got %h want 0001", count_bcd); end
    if (count_hex !== 16'h0001) begin errors++; $display("FAIL repress_hex: got %h want 0001", count_hex); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_random();
    test_scan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
